// File: rtl/reg_out_stream_if.sv
// Output stream of reg_out_stream: FIFO head presented with valid/ready.
interface reg_out_stream_if #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 1
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;

  modport master (output out_valid, out_data, out_ch, input out_ready);
  modport slave  (input out_valid, out_data, out_ch, output out_ready);
endinterface

// File: rtl/reg_out_stream.sv
// Register-file writeback snooper: armed writes to watched registers feed a valid/ready FIFO.
// Optional CHANGE_ONLY_EN drops pushes that repeat a channel's last pushed value.
module reg_out_stream #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 1,
  parameter int WATCH_BASE = 10,
  parameter int DEPTH      = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  input  logic              clear_ovf,
  reg_out_stream_if.master  os,
  output logic [DATA_W-1:0] data_out,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
);
  localparam int PTR_W = LVL_W - 1;
  localparam logic [5:0] ADDR_LO = 6'(WATCH_BASE);
  localparam logic [5:0] ADDR_HI = 6'(WATCH_BASE + NUM_CH);

  typedef enum logic {IDLE, ARMED} state_e;
  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e                  state_q;
  logic                    trig_q;
  entry_t [DEPTH-1:0]      mem_q, mem_d;
  logic [LVL_W-1:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]       dout_q, dout_d;
  logic                    ovf_q, ovf_d;

  logic                    hit, armed, pop, full, push_req, push, drop;
  logic [CH_W-1:0]         ch;
  logic [DATA_W-1:0]       cap;
  logic [5:0]              addr_ext;
  logic                    unused_wb;

  assign unused_wb = ^wb_data;
  assign addr_ext  = {1'b0, wb_addr};
  assign cap       = wb_data[DATA_W-1:0];
  assign ch        = CH_W'(wb_addr - 5'(WATCH_BASE));
  // Address 0 is hardwired zero in the register file, so it never counts as a hit.
  assign hit       = wb_en && (wb_addr != 5'd0) && (addr_ext >= ADDR_LO) && (addr_ext < ADDR_HI);
  assign armed     = (state_q == ARMED);
  assign level     = wr_cnt_q - rd_cnt_q;
  assign full      = (level == LVL_W'(DEPTH));
  assign pop       = (level != '0) && os.out_ready;

`ifdef CHANGE_ONLY_EN
  logic [NUM_CH-1:0][DATA_W-1:0] last_q, last_d;
  logic [NUM_CH-1:0]             lv_q, lv_d;
  logic                          dup;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch == CH_W'(i) && lv_q[i] && last_q[i] == cap) dup = 1'b1;
  end
  assign push_req = hit && armed && !dup;

  always_comb begin
    last_d = last_q;
    lv_d   = lv_q;
    for (int i = 0; i < NUM_CH; i++)
      if (push && ch == CH_W'(i)) begin
        last_d[i] = cap;
        lv_d[i]   = 1'b1;
      end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_q <= '0;
      lv_q   <= '0;
    end else begin
      last_q <= last_d;
      lv_q   <= lv_d;
    end
`else
  assign push_req = hit && armed;
`endif

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (push) begin
      mem_d[wr_cnt_q[PTR_W-1:0]] = '{ch: ch, data: cap};
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    if (pop) rd_cnt_d = rd_cnt_q + 1'b1;
    dout_d = (hit && ch == '0) ? cap : dout_q;
    ovf_d  = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
    end

  // Arming is one-shot: only reset returns to IDLE.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
    end else begin
      trig_q <= trigger;
      if (state_q == IDLE && trigger && !trig_q) state_q <= ARMED;
    end

  assign os.out_valid = (level != '0);
  assign os.out_data  = mem_q[rd_cnt_q[PTR_W-1:0]].data;
  assign os.out_ch    = mem_q[rd_cnt_q[PTR_W-1:0]].ch;
  assign data_out     = dout_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_reg_out_stream.sv
// Bench for reg_out_stream (NUM_CH=4): directed scenarios then random traffic vs a queue model.
module tb_reg_out_stream;
  localparam int DW = 8, NC = 4, WB = 10, DP = 16, CW = 2, LW = 5;

  logic          clk = 1'b0;
  logic          rst, trigger, wb_en, clear_ovf;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic [DW-1:0] data_out;
  logic [LW-1:0] level;
  logic          overflow;

  reg_out_stream_if #(.DATA_W(DW), .CH_W(CW)) sif ();

  reg_out_stream #(.DATA_W(DW), .NUM_CH(NC), .WATCH_BASE(WB), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .clear_ovf(clear_ovf), .os(sif), .data_out(data_out),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int qd[$], qc[$];
  int m_dout, m_last[NC];
  bit m_armed, m_trig, m_ovf, m_lv[NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    qd.delete(); qc.delete();
    m_dout = 0; m_armed = 0; m_trig = 0; m_ovf = 0;
    for (int i = 0; i < NC; i++) begin m_last[i] = 0; m_lv[i] = 0; end
  endtask

  // Applies the current input values to the model as one clock edge.
  task automatic model_step();
    int a, d, c;
    bit hit, req, pop, full, dropped;
    a = int'(wb_addr); d = int'(wb_data[7:0]); c = a - WB;
    hit = wb_en && a != 0 && a >= WB && a < WB + NC;
    req = hit && m_armed;
`ifdef CHANGE_ONLY_EN
    if (req && m_lv[c] && m_last[c] == d) req = 0;
`endif
    pop = qd.size() != 0 && sif.out_ready;
    full = qd.size() == DP;
    dropped = 0;
    if (pop) begin void'(qd.pop_front()); void'(qc.pop_front()); end
    if (req) begin
      if (!full || pop) begin
        qd.push_back(d); qc.push_back(c);
        m_last[c] = d; m_lv[c] = 1;
      end else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;
    if (hit && c == 0) m_dout = d;
    if (trigger && !m_trig) m_armed = 1;
    m_trig = trigger;
  endtask

  task automatic check_outputs();
    chk("out_valid", sif.out_valid, qd.size() != 0);
    chk("level", level, qd.size());
    chk("data_out", data_out, m_dout);
    chk("overflow", overflow, m_ovf);
    if (qd.size() != 0) begin
      chk("head_data", sif.out_data, qd[0]);
      chk("head_ch", sif.out_ch, qc[0]);
    end
  endtask

  task automatic cyc(input bit tr, input bit en, input int a, input int d, input bit rdy, input bit clr);
    trigger = tr; wb_en = en; wb_addr = 5'(a); wb_data = d; sif.out_ready = rdy; clear_ovf = clr;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wr(input int a, input int d, input bit rdy);
    cyc(0, 1, a, d, rdy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && qd.size() != 0; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("drain_empty", level, 0);
  endtask

  initial begin
    rst = 1; trigger = 0; wb_en = 0; wb_addr = 0; wb_data = 0; clear_ovf = 0; sif.out_ready = 0;
    model_reset();
    #12;
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_head", {sif.out_ch, sif.out_data}, 0);
    rst = 0;

    // Writes before arming only update data_out.
    wr(10, 32'h1234, 0);
    chk("t1_dout", data_out, 32'h34);
    chk("t1_level0", level, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    wr(10, 32'h55, 0);
    chk("t1_valid", sif.out_valid, 1);
    chk("t1_data", sif.out_data, 32'h55);
    chk("t1_level1", level, 1);
    drain();

    // Overflow with consumer stalled, then pop everything in order.
    for (int i = 0; i <= 16; i++) wr(10, i, 0);
    chk("t2_level", level, 16);
    chk("t2_ovf", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_pop", sif.out_data, i);
      cyc(0, 0, 0, 0, 1, 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk("t2_clr", overflow, 0);

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 16; i++) wr(10, 32'h20 + i, 0);
    wr(10, 32'h99, 1);
    chk("t3_level", level, 16);
    chk("t3_ovf", overflow, 0);
    drain();

    // Channel decode: x13 hits, x14 / x0 / disabled writes do not.
    wr(10, 1, 0); wr(13, 2, 0); wr(14, 3, 0); wr(0, 4, 0);
    cyc(0, 0, 11, 5, 0, 0);
    chk("t4_level", level, 2);
    drain();

    // Repeated value on one channel.
    wr(10, 7, 0); wr(10, 7, 0); wr(10, 8, 0); wr(10, 7, 0);
`ifdef CHANGE_ONLY_EN
    chk("t6_level", level, 3);
`else
    chk("t6_level", level, 4);
`endif
    drain();

    // Asynchronous reset mid-pop.
    for (int i = 0; i < 5; i++) wr(11, 40 + i, 0);
    wr(10, 32'h77, 0);
    sif.out_ready = 1; wb_en = 0;
    #2 rst = 1;
    #1;
    chk("t5_valid", sif.out_valid, 0);
    chk("t5_level", level, 0);
    chk("t5_dout", data_out, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    check_outputs();
    wr(10, 3, 0);
    chk("t5_disarmed", level, 0);

    // Random traffic.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      int a, d;
      a = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(8, 15);
      d = int'(($urandom() & 32'hFFFF_FF00) | $urandom_range(0, 3));
      cyc($urandom_range(0, 1), $urandom_range(0, 3) != 0, a, d,
          (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
